emu_code_nco_mc: RTL and testbench
==================================

# emu_code_nco_mc

Multi-channel C/A code NCO for the GPS synthesizer. One time-multiplexed datapath serves NCH independent channels. Each channel has its own PRN, code-rate phase increment and enable. Every accepted sample strobe advances all channels by one sample and emits one C/A chip bit per channel, so several satellites can feed the downstream modulator/summer from a single instance.

## Interface
Parameters:
- NCH, 4, number of channels (1–16)
- PHASE_W, 32, phase accumulator width; freq = chip_rate/sample_rate · 2^PHASE_W

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- ca_sel  in  6·NCH  per-channel PRN number, channel k at [6k+5:6k]; valid 1–32
- freq  in  PHASE_W·NCH  per-channel phase increment, channel k at [PHASE_W·k +: PHASE_W]
- ch_en  in  NCH  per-channel enable
- sync  in  1  synchronous clear of all channel code/phase state
- dv_in  in  1  sample strobe, single cycle
- dv_out  out  1  one-cycle pulse: q/epoch updated
- q  out  NCH  per-channel chip bit for the current sample
- epoch  out  NCH  per-channel code-epoch flag, qualified by dv_out
- overrun  out  1  sticky; set when dv_in is dropped, cleared by reset or sync

## Operation
- Per-channel state: phase[PHASE_W-1:0], chip_cnt[9:0] (0–1022), G1[10:1], G2[10:1].
- Reset/sync value of the state: phase=0, chip_cnt=0, G1=G2=all ones.
- G1 = 1+x³+x¹⁰; G2 = 1+x²+x³+x⁶+x⁸+x⁹+x¹⁰.
- Chip = G1[10] ^ (G2[a] ^ G2[b]), with (a,b) taken from the IS-GPS-200 phase-selector table for PRN 1–32. The table is a combinational lookup on ca_sel.
- ca_sel outside 1–32: chip forced 0. Channel state still advances.
- Sequencer FSM: IDLE → RUN (NCH cycles, index 0..NCH-1) → DONE (1 cycle) → IDLE.
- RUN, channel k with ch_en[k]=1:
  - sum = phase + freq (PHASE_W+1 bits); phase ← sum[PHASE_W-1:0].
  - If sum carries: shift G1 and G2 once, chip_cnt+1.
  - When chip_cnt=1022 and the channel carries: chip_cnt←0, G1=G2←all ones, epoch bit k set.
  - Freq is below 2^PHASE_W, so at most one chip advances per sample.
- RUN, channel k with ch_en[k]=0: state frozen; q[k]=0, epoch[k]=0.
- q[k] = chip at the post-update state. q and epoch are staged during RUN and transferred to the outputs in DONE.
- ca_sel, freq and ch_en are sampled when channel k is processed. Changing them does not disturb stored state.

## Timing
- Reset values: dv_out=0, q=0, epoch=0, overrun=0, FSM=IDLE.
- dv_in in IDLE is accepted. RUN starts on the next cycle.
- dv_out pulses NCH+1 cycles after the accepted dv_in. q and epoch change only on that cycle and hold until the next dv_out.
- Minimum dv_in spacing is NCH+2 cycles.
- dv_in arriving while in RUN or DONE is dropped and sets overrun. In-flight processing is unaffected.
- sync has priority over everything:
  - Clears all channel state and overrun.
  - Returns the FSM to IDLE with no dv_out for the aborted sweep.
  - A dv_in on the same cycle is dropped without setting overrun.
  - q and epoch clear to 0.
- Asynchronous reset mid-sweep: all outputs return to reset values immediately. No dv_out is produced.
- Phase wrap is modulo 2^PHASE_W. The carry is the only chip-advance event.

## Test plan
- **PRN sequences:** NCH=4, PHASE_W=32, ch0 PRN3 with freq=2^30, dv_in every 64 cycles. Expected: q[0] is chip0=1 for samples 1–3, then each chip is held 4 samples. The first 10 chips are 1111001000 (octal 1710). Also check ch1..3 with PRN1/2/4 against first-chip octal values 1440/1620/1744.
- **Epoch and wrap:** same setup, 1023·5 samples. Expected: epoch[0] pulses on samples 4092, 8184, …. chip_cnt never exceeds 1022. The q sequence repeats exactly every 4092 samples.
- **Fractional rate:** freq=2^32/4.25 for 200 samples. Expected: chip dwell alternates 4/5 samples. There are exactly floor(200·4/17) chip advances, checked against a reference-model accumulator.
- **Latency and overrun:** dv_out exactly NCH+1 cycles after dv_in. Issue a second dv_in 2 cycles after the first: expect one dv_out and overrun=1. A later sync clears overrun.
- **Enable/invalid PRN:** ch_en[2]=0 for 100 samples, then 1. Expected: q[2]=0 while disabled and the code resumes from the frozen chip. Set ca_sel=0 on ch3: expect q[3]=0 while epoch timing is unchanged.
- **Sync/reset mid-sweep:** assert sync during RUN together with dv_in. Expected: no dv_out, no overrun, and the next sample restarts at chip0. Async reset mid-sweep: outputs are 0 on the same edge.

Source files
------------

// File: rtl/emu_code_nco_mc.sv
// emu_code_nco_mc: time-multiplexed multi-channel GPS C/A code NCO.
// A single phase-accumulator/Gold-code datapath visits every channel once per
// accepted sample strobe. It stages the per-channel chip and epoch bits, then
// publishes all of them together with a one-cycle dv_out pulse.
module emu_code_nco_mc #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6*NCH-1:0]       ca_sel,
    input  logic [PHASE_W*NCH-1:0] freq,
    input  logic [NCH-1:0]         ch_en,
    input  logic                   sync,
    input  logic                   dv_in,
    output logic                   dv_out,
    output logic [NCH-1:0]         q,
    output logic [NCH-1:0]         epoch,
    output logic                   overrun
);
    localparam int               IDX_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);
    localparam logic [9:0]       LAST_CHIP = 10'd1022;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_w;

    // Per-channel stored state.
    logic [PHASE_W-1:0] phase    [NCH];
    logic [9:0]         chip_cnt [NCH];
    logic [10:1]        g1       [NCH];
    logic [10:1]        g2       [NCH];

    // Results gathered during the sweep, published in DONE.
    logic [NCH-1:0] q_stage, epoch_stage;

    // Shared datapath for the channel under the sequencer index.
    logic [5:0]         cur_sel;
    logic [PHASE_W-1:0] cur_freq;
    logic               cur_en;
    logic [PHASE_W:0]   sum;
    logic               carry, wrap;
    logic [9:0]         cnt_nxt;
    logic [10:1]        g1_nxt, g2_nxt;
    logic [8:0]         taps;
    logic [10:1]        sel_mask;
    logic               chip_nxt;

    // IS-GPS-200 G2 phase-selector taps: {valid, tap_a, tap_b}; invalid PRN -> 0.
    function automatic logic [8:0] prn_taps(input logic [5:0] prn);
        case (prn)
            6'd1:    prn_taps = {1'b1, 4'd2, 4'd6};
            6'd2:    prn_taps = {1'b1, 4'd3, 4'd7};
            6'd3:    prn_taps = {1'b1, 4'd4, 4'd8};
            6'd4:    prn_taps = {1'b1, 4'd5, 4'd9};
            6'd5:    prn_taps = {1'b1, 4'd1, 4'd9};
            6'd6:    prn_taps = {1'b1, 4'd2, 4'd10};
            6'd7:    prn_taps = {1'b1, 4'd1, 4'd8};
            6'd8:    prn_taps = {1'b1, 4'd2, 4'd9};
            6'd9:    prn_taps = {1'b1, 4'd3, 4'd10};
            6'd10:   prn_taps = {1'b1, 4'd2, 4'd3};
            6'd11:   prn_taps = {1'b1, 4'd3, 4'd4};
            6'd12:   prn_taps = {1'b1, 4'd5, 4'd6};
            6'd13:   prn_taps = {1'b1, 4'd6, 4'd7};
            6'd14:   prn_taps = {1'b1, 4'd7, 4'd8};
            6'd15:   prn_taps = {1'b1, 4'd8, 4'd9};
            6'd16:   prn_taps = {1'b1, 4'd9, 4'd10};
            6'd17:   prn_taps = {1'b1, 4'd1, 4'd4};
            6'd18:   prn_taps = {1'b1, 4'd2, 4'd5};
            6'd19:   prn_taps = {1'b1, 4'd3, 4'd6};
            6'd20:   prn_taps = {1'b1, 4'd4, 4'd7};
            6'd21:   prn_taps = {1'b1, 4'd5, 4'd8};
            6'd22:   prn_taps = {1'b1, 4'd6, 4'd9};
            6'd23:   prn_taps = {1'b1, 4'd1, 4'd3};
            6'd24:   prn_taps = {1'b1, 4'd4, 4'd6};
            6'd25:   prn_taps = {1'b1, 4'd5, 4'd7};
            6'd26:   prn_taps = {1'b1, 4'd6, 4'd8};
            6'd27:   prn_taps = {1'b1, 4'd7, 4'd9};
            6'd28:   prn_taps = {1'b1, 4'd8, 4'd10};
            6'd29:   prn_taps = {1'b1, 4'd1, 4'd6};
            6'd30:   prn_taps = {1'b1, 4'd2, 4'd7};
            6'd31:   prn_taps = {1'b1, 4'd3, 4'd8};
            6'd32:   prn_taps = {1'b1, 4'd4, 4'd9};
            default: prn_taps = 9'd0;
        endcase
    endfunction

    assign idx_w = 32'(idx);

    // Next phase, chip counter, LFSRs and chip bit for the channel being visited.
    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        cur_sel  = ca_sel[6*idx_w +: 6];
        cur_freq = freq[PHASE_W*idx_w +: PHASE_W];
        cur_en   = ch_en[idx];
        sum      = {1'b0, phase[idx]} + {1'b0, cur_freq};
        carry    = sum[PHASE_W];
        wrap     = carry && (chip_cnt[idx] == LAST_CHIP);
        cnt_nxt  = chip_cnt[idx];
        g1_nxt   = g1[idx];
        g2_nxt   = g2[idx];
        if (wrap) begin
            cnt_nxt = 10'd0;
            g1_nxt  = '1;
            g2_nxt  = '1;
        end else if (carry) begin
            cnt_nxt = chip_cnt[idx] + 10'd1;
            g1_nxt  = {g1[idx][9:1], g1[idx][3] ^ g1[idx][10]};
            g2_nxt  = {g2[idx][9:1], g2[idx][2] ^ g2[idx][3] ^ g2[idx][6]
                                   ^ g2[idx][8] ^ g2[idx][9] ^ g2[idx][10]};
        end
        taps     = prn_taps(cur_sel);
        sel_mask = '0;
        if (taps[8]) begin
            sel_mask[taps[7:4]] = 1'b1;
            sel_mask[taps[3:0]] = 1'b1;
        end
        chip_nxt = taps[8] & (g1_nxt[10] ^ (^(g2_nxt & sel_mask)));
    end

    // Sequencer next state; sync aborts any sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dv_in) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (sync) state_nxt = IDLE;
    end

    // Sequencer state register.
    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Channel index walks 0..NCH-1 during RUN and rests at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          idx <= '0;
        else if (sync || state != RUN)      idx <= '0;
        else if (idx != LAST_IDX)           idx <= idx + 1'b1;
        else                                idx <= '0;
    end

    // Per-channel code/phase state; only the enabled channel under the index moves.
    // NOTE: the channel arrays are reset explicitly, since sync and reset must both leave a known code phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                phase[k]    <= '0;
                chip_cnt[k] <= '0;
                g1[k]       <= '1;
                g2[k]       <= '1;
            end
        end else if (sync) begin
            for (int k = 0; k < NCH; k++) begin
                phase[k]    <= '0;
                chip_cnt[k] <= '0;
                g1[k]       <= '1;
                g2[k]       <= '1;
            end
        end else if (state == RUN && cur_en) begin
            phase[idx]    <= sum[PHASE_W-1:0];
            chip_cnt[idx] <= cnt_nxt;
            g1[idx]       <= g1_nxt;
            g2[idx]       <= g2_nxt;
        end
    end

    // Stage chip/epoch bits as each channel is visited; disabled channels stage zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_stage     <= '0;
            epoch_stage <= '0;
        end else if (sync) begin
            q_stage     <= '0;
            epoch_stage <= '0;
        end else if (state == RUN) begin
            q_stage[idx]     <= cur_en & chip_nxt;
            epoch_stage[idx] <= cur_en & wrap;
        end
    end

    // Publish staged results with a single-cycle dv_out in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_out <= 1'b0;
            q      <= '0;
            epoch  <= '0;
        end else if (sync) begin
            dv_out <= 1'b0;
            q      <= '0;
            epoch  <= '0;
        end else begin
            dv_out <= (state == DONE);
            if (state == DONE) begin
                q     <= q_stage;
                epoch <= epoch_stage;
            end
        end
    end

    // Sticky flag for strobes that arrive while a sweep is still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          overrun <= 1'b0;
        else if (sync)                      overrun <= 1'b0;
        else if (dv_in && state != IDLE)    overrun <= 1'b1;
    end

endmodule

// File: tb/tb_emu_code_nco_mc.sv
// Self-checking bench for emu_code_nco_mc.
// Reference model: per channel, a phase accumulator plus a chip index into a
// precomputed 1023-chip Gold-code table. The table is built as G1 xor a delayed G2.
module tb_emu_code_nco_mc;
    localparam int NCH     = 4;
    localparam int PHASE_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [6*NCH-1:0]       ca_sel;
    logic [PHASE_W*NCH-1:0] freq;
    logic [NCH-1:0]         ch_en;
    logic                   sync;
    logic                   dv_in;
    logic                   dv_out;
    logic [NCH-1:0]         q;
    logic [NCH-1:0]         epoch;
    logic                   overrun;

    emu_code_nco_mc #(.NCH(NCH), .PHASE_W(PHASE_W)) dut (
        .clk(clk), .reset(reset), .ca_sel(ca_sel), .freq(freq), .ch_en(ch_en),
        .sync(sync), .dv_in(dv_in), .dv_out(dv_out), .q(q), .epoch(epoch),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    bit                 code [0:32][0:1022];
    logic [PHASE_W-1:0] m_phase [NCH];
    int                 m_cidx  [NCH];
    int                 m_adv   [NCH];
    logic [NCH-1:0]     pend_q, pend_ep;

    // Expected outputs, updated by the driver just after each active edge.
    logic           exp_dv      = 1'b0;
    logic [NCH-1:0] exp_q       = '0;
    logic [NCH-1:0] exp_epoch   = '0;
    logic           exp_overrun = 1'b0;
    logic           chk_on      = 1'b0;

    // DUT values captured on the dv_out cycle of the most recent sample.
    logic [NCH-1:0] dut_q, dut_ep;
    int             last_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // G2 delays (chips) for PRN 1..32.
    int g2_delay [32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256,
                          257, 258, 469, 470, 471, 472, 473, 474, 509, 512, 513, 514,
                          515, 516, 859, 860, 861, 862};

    task automatic build_codes();
        bit          g1s [1023];
        bit          g2s [1023];
        logic [10:1] r1, r2;
        r1 = '1;
        r2 = '1;
        for (int n = 0; n < 1023; n++) begin
            g1s[n] = r1[10];
            g2s[n] = r2[10];
            r1 = {r1[9:1], r1[3] ^ r1[10]};
            r2 = {r2[9:1], r2[2] ^ r2[3] ^ r2[6] ^ r2[8] ^ r2[9] ^ r2[10]};
        end
        for (int p = 0; p <= 32; p++)
            for (int n = 0; n < 1023; n++)
                code[p][n] = (p == 0) ? 1'b0 : (g1s[n] ^ g2s[(n - g2_delay[p-1] + 1023) % 1023]);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_phase[k] = '0;
            m_cidx[k]  = 0;
            m_adv[k]   = 0;
        end
    endtask

    // Advance every channel by one sample using the current inputs.
    task automatic model_advance();
        for (int k = 0; k < NCH; k++) begin
            logic [PHASE_W:0] s;
            int               prn;
            prn = int'(ca_sel[6*k +: 6]);
            pend_q[k]  = 1'b0;
            pend_ep[k] = 1'b0;
            if (ch_en[k]) begin
                s = {1'b0, m_phase[k]} + {1'b0, freq[PHASE_W*k +: PHASE_W]};
                m_phase[k] = s[PHASE_W-1:0];
                if (s[PHASE_W]) begin
                    m_cidx[k]  = (m_cidx[k] + 1) % 1023;
                    m_adv[k]   = m_adv[k] + 1;
                    pend_ep[k] = (m_cidx[k] == 0);
                end
                pend_q[k] = (prn >= 1 && prn <= 32) ? code[prn][m_cidx[k]] : 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample strobe from IDLE; dup>0 adds a stray dv_in dup edges after acceptance.
    task automatic do_sample(input int dup);
        model_advance();
        dv_in = 1'b1;
        tick();
        dv_in    = 1'b0;
        last_lat = -1;
        for (int e = 1; e <= NCH + 1; e++) begin
            if (e == dup) dv_in = 1'b1;
            tick();
            dv_in = 1'b0;
            if (e == dup) exp_overrun = 1'b1;
            if (dv_out && last_lat < 0) last_lat = e;
            if (e == NCH + 1) begin
                exp_dv    = 1'b1;
                exp_q     = pend_q;
                exp_epoch = pend_ep;
                dut_q     = q;
                dut_ep    = epoch;
            end
        end
        tick();
        exp_dv = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        model_clear();
        exp_q       = '0;
        exp_epoch   = '0;
        exp_overrun = 1'b0;
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("dv_out",  32'(dv_out),  32'(exp_dv));
            check("q",       32'(q),       32'(exp_q));
            check("epoch",   32'(epoch),   32'(exp_epoch));
            check("overrun", 32'(overrun), 32'(exp_overrun));
        end
    end

    logic [9:0] exp_oct [NCH] = '{10'o1710, 10'o1440, 10'o1620, 10'o1744};
    bit         rec [NCH][41];

    initial begin
        int first_ep;
        int ep_cnt;
        logic [9:0] word;

        reset  = 1'b1;
        sync   = 1'b0;
        dv_in  = 1'b0;
        ch_en  = '0;
        ca_sel = '0;
        freq   = '0;
        build_codes();
        model_clear();
        tick();
        chk_on = 1'b1;
        tick();
        check("rst_dv_out",  32'(dv_out),  32'd0);
        check("rst_q",       32'(q),       32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // PRN sequences, epoch and wrap: ch0..3 = PRN 3,1,2,4 at a quarter chip per sample.
        ca_sel = {6'd4, 6'd2, 6'd1, 6'd3};
        freq   = {NCH{32'h4000_0000}};
        ch_en  = '1;
        first_ep = 0;
        ep_cnt   = 0;
        for (int s = 1; s <= 4100; s++) begin
            do_sample(0);
            if (s <= 40)
                for (int k = 0; k < NCH; k++) rec[k][s] = dut_q[k];
            if (dut_ep[0]) begin
                ep_cnt++;
                if (first_ep == 0) first_ep = s;
            end
        end
        check("latency", 32'(last_lat), 32'(NCH + 1));
        for (int k = 0; k < NCH; k++) begin
            word = '0;
            for (int c = 0; c < 10; c++)
                word = {word[8:0], rec[k][(c == 0) ? 1 : 4*c]};
            check($sformatf("first10_ch%0d", k), 32'(word), 32'(exp_oct[k]));
        end
        check("first_epoch_sample", 32'(first_ep), 32'd4092);
        check("epoch_count",        32'(ep_cnt),   32'd1);
        check("model_adv_ch0",      32'(m_adv[0]), 32'd1025);

        // Latency and overrun: stray dv_in two cycles after acceptance.
        do_sample(2);
        check("overrun_set", 32'(overrun), 32'd1);
        do_sync();
        tick();
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Fractional rate: 2^32/4.25 -> floor(200*4/17) = 47 chip advances.
        freq[0 +: PHASE_W] = 32'd1010580540;
        for (int s = 0; s < 200; s++) do_sample(0);
        check("frac_adv_ch0", 32'(m_adv[0]), 32'd47);

        // Enable and invalid PRN: ch2 disabled for 100 samples, ch3 PRN 0.
        do_sync();
        freq = {NCH{32'h4000_0000}};
        ca_sel[18 +: 6] = 6'd0;
        ch_en = 4'b1011;
        for (int s = 0; s < 100; s++) do_sample(0);
        check("q2_disabled", 32'(dut_q[2]), 32'd0);
        ch_en = 4'b1111;
        for (int s = 0; s < 50; s++) do_sample(0);
        check("q3_invalid", 32'(dut_q[3]), 32'd0);
        ca_sel[18 +: 6] = 6'd4;

        // Sync mid-sweep together with dv_in: no dv_out, no overrun, restart at chip0.
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        tick();
        tick();
        sync  = 1'b1;
        dv_in = 1'b1;
        tick();
        sync  = 1'b0;
        dv_in = 1'b0;
        model_clear();
        exp_q       = '0;
        exp_epoch   = '0;
        exp_overrun = 1'b0;
        repeat (NCH + 3) tick();
        check("sync_no_overrun", 32'(overrun), 32'd0);
        do_sample(0);
        check("restart_chip0", 32'(dut_q), 32'hF);

        // Asynchronous reset mid-sweep, with overrun and q set beforehand.
        do_sample(3);
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        model_clear();
        exp_dv      = 1'b0;
        exp_q       = '0;
        exp_epoch   = '0;
        exp_overrun = 1'b0;
        #1;
        check("areset_q",       32'(q),       32'd0);
        check("areset_dv_out",  32'(dv_out),  32'd0);
        check("areset_overrun", 32'(overrun), 32'd0);
        tick();
        reset = 1'b0;
        repeat (NCH + 3) tick();

        // Randomized configurations, strobe spacing, stray strobes and syncs.
        for (int s = 0; s < 600; s++) begin
            if (s % 25 == 0) begin
                for (int k = 0; k < NCH; k++) begin
                    ca_sel[6*k +: 6]        = 6'($urandom_range(0, 35));
                    freq[PHASE_W*k +: PHASE_W] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) << 24 : $urandom();
                end
                ch_en = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 59) == 0) do_sync();
            do_sample(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, NCH + 1)) : 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
